// File: rtl/anabellek_hakem.sv
// anabellek_hakem
// Main-memory arbiter. It multiplexes N requester channels onto the single
// iomem port, with fixed or round-robin priority, a bus timeout and a sticky
// error flag. It also holds a free-running 64-bit cycle counter whose high
// word is snapshotted on every low-word read, so a 64-bit value read in two
// halves is never torn.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ist_valid_i [N]       per-channel request (held until its ready pulse)
//   ist_ready_o [N]       one-cycle completion pulse for the granted channel
//   ist_wstrb_i [4N]      byte strobes, channel k in [4k+3:4k], 0 = read
//   ist_addr_i  [ADR_BIT*N] word address, channel k in slice k
//   ist_wdata_i [32N]     write data, channel k in slice k
//   ist_rdata_o [32]      shared read data, valid with ist_ready_o
//   iomem_*               registered main-memory request port
//   tmr_sec_i, tmr_adr_i  timer read select / address (bit 2: 0 low, 1 high)
//   tmr_veri_o [32]       combinational timer read data
//   hata_o                sticky timeout flag, cleared by hata_temizle_i
module anabellek_hakem #(
   parameter int          KANAL_SAYISI = 3,
   parameter int          ADR_BIT      = 17,
   parameter logic [31:0] TABAN_ADR    = 32'h4000_0000,
   parameter int          ONCELIK_MODU = 1,
   parameter int          ZAMAN_ASIMI  = 1024
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [KANAL_SAYISI-1:0]         ist_valid_i,
   output logic [KANAL_SAYISI-1:0]         ist_ready_o,
   input  logic [4*KANAL_SAYISI-1:0]       ist_wstrb_i,
   input  logic [ADR_BIT*KANAL_SAYISI-1:0] ist_addr_i,
   input  logic [32*KANAL_SAYISI-1:0]      ist_wdata_i,
   output logic [31:0]                     ist_rdata_o,
   output logic                            iomem_valid,
   input  logic                            iomem_ready,
   output logic [3:0]                      iomem_wstrb,
   output logic [31:0]                     iomem_addr,
   output logic [31:0]                     iomem_wdata,
   input  logic [31:0]                     iomem_rdata,
   input  logic                            tmr_sec_i,
   input  logic [31:0]                     tmr_adr_i,
   output logic [31:0]                     tmr_veri_o,
   output logic                            hata_o,
   input  logic                            hata_temizle_i
);

   localparam int N     = KANAL_SAYISI;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = (ZAMAN_ASIMI > 0) ? $clog2(ZAMAN_ASIMI + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ZAMAN_ASIMI);
   // Bits of iomem_addr owned by the channel word address plus byte offset;
   // the rest come from TABAN_ADR. Built in 64 bits so ADR_BIT+2 = 32 works.
   localparam logic [63:0] ADR_MASK_64 = (64'd1 << (ADR_BIT + 2)) - 64'd1;
   localparam logic [31:0] ADR_MASK    = ADR_MASK_64[31:0];
   localparam logic [31:0] HATA_VERI   = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {BOSTA, ISTEK, TAMAM} durum_t;

   durum_t             durum_q, durum_d;
   logic [IDX_W-1:0]   son_q, son_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               iomem_valid_q, iomem_valid_d;
   logic [3:0]         iomem_wstrb_q, iomem_wstrb_d;
   logic [31:0]        iomem_addr_q, iomem_addr_d;
   logic [31:0]        iomem_wdata_q, iomem_wdata_d;
   logic [N-1:0]       ist_ready_q, ist_ready_d;
   logic [31:0]        ist_rdata_q, ist_rdata_d;
   logic               hata_q, hata_d;
   logic [63:0]        sayac_q, sayac_d;
   logic [31:0]        ust_kopya_q, ust_kopya_d;

   logic [ADR_BIT-1:0] adr_dizi   [N];
   logic [3:0]         wstrb_dizi [N];
   logic [31:0]        wdata_dizi [N];

   logic [IDX_W-1:0]   kazanan;
   logic               bulundu;
   int                 aday;
   logic               tmr_adr_unused;

   for (genvar k = 0; k < N; k++) begin : g_ayir
      assign adr_dizi[k]   = ist_addr_i[k*ADR_BIT +: ADR_BIT];
      assign wstrb_dizi[k] = ist_wstrb_i[4*k +: 4];
      assign wdata_dizi[k] = ist_wdata_i[32*k +: 32];
   end

   // Winner search. Round-robin starts one past the last grant and wraps;
   // since son < N and i < N a single subtraction is enough for the modulo.
   always_comb begin
      kazanan = '0;
      bulundu = 1'b0;
      aday    = 0;
      for (int i = 0; i < N; i++) begin
         if (ONCELIK_MODU == 0) begin
            aday = i;
         end else begin
            aday = int'(son_q) + 1 + i;
            if (aday >= N) aday = aday - N;
         end
         if (!bulundu && ist_valid_i[IDX_W'(aday)]) begin
            bulundu = 1'b1;
            kazanan = IDX_W'(aday);
         end
      end
   end

   always_comb begin
      durum_d       = durum_q;
      son_d         = son_q;
      cnt_d         = cnt_q;
      iomem_valid_d = iomem_valid_q;
      iomem_wstrb_d = iomem_wstrb_q;
      iomem_addr_d  = iomem_addr_q;
      iomem_wdata_d = iomem_wdata_q;
      ist_ready_d   = '0;
      ist_rdata_d   = ist_rdata_q;
      sayac_d       = sayac_q + 64'd1;
      ust_kopya_d   = ust_kopya_q;
      hata_d        = hata_q;

      // Clear first so that a timeout in the same cycle still wins below.
      if (hata_temizle_i) hata_d = 1'b0;

      if (tmr_sec_i && !tmr_adr_i[2]) ust_kopya_d = sayac_q[63:32];

      case (durum_q)
         BOSTA: begin
            if (bulundu) begin
               durum_d       = ISTEK;
               son_d         = kazanan;
               cnt_d         = '0;
               iomem_valid_d = 1'b1;
               iomem_wstrb_d = wstrb_dizi[kazanan];
               iomem_wdata_d = wdata_dizi[kazanan];
               iomem_addr_d  = (TABAN_ADR & ~ADR_MASK) | (32'(adr_dizi[kazanan]) << 2);
            end
         end
         ISTEK: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (iomem_ready) begin
               durum_d            = TAMAM;
               iomem_valid_d      = 1'b0;
               ist_rdata_d        = iomem_rdata;
               ist_ready_d[son_q] = 1'b1;
            end else if (ZAMAN_ASIMI != 0 && cnt_q == CNT_LIMIT) begin
               durum_d            = TAMAM;
               iomem_valid_d      = 1'b0;
               ist_rdata_d        = HATA_VERI;
               ist_ready_d[son_q] = 1'b1;
               hata_d             = 1'b1;
            end
         end
         TAMAM: begin
            durum_d = BOSTA;
         end
         default: begin
            durum_d = BOSTA;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_q       <= BOSTA;
         son_q         <= IDX_W'(N - 1);
         cnt_q         <= '0;
         iomem_valid_q <= 1'b0;
         iomem_wstrb_q <= '0;
         iomem_addr_q  <= '0;
         iomem_wdata_q <= '0;
         ist_ready_q   <= '0;
         ist_rdata_q   <= '0;
         hata_q        <= 1'b0;
         sayac_q       <= '0;
         ust_kopya_q   <= '0;
      end else begin
         durum_q       <= durum_d;
         son_q         <= son_d;
         cnt_q         <= cnt_d;
         iomem_valid_q <= iomem_valid_d;
         iomem_wstrb_q <= iomem_wstrb_d;
         iomem_addr_q  <= iomem_addr_d;
         iomem_wdata_q <= iomem_wdata_d;
         ist_ready_q   <= ist_ready_d;
         ist_rdata_q   <= ist_rdata_d;
         hata_q        <= hata_d;
         sayac_q       <= sayac_d;
         ust_kopya_q   <= ust_kopya_d;
      end
   end

   assign ist_ready_o = ist_ready_q;
   assign ist_rdata_o = ist_rdata_q;
   assign iomem_valid = iomem_valid_q;
   assign iomem_wstrb = iomem_wstrb_q;
   assign iomem_addr  = iomem_addr_q;
   assign iomem_wdata = iomem_wdata_q;
   assign hata_o      = hata_q;

   // Only bit 2 of the timer address selects the word.
   assign tmr_veri_o = !tmr_sec_i ? 32'd0 : (tmr_adr_i[2] ? ust_kopya_q : sayac_q[31:0]);
   assign tmr_adr_unused = ^{tmr_adr_i[31:3], tmr_adr_i[1:0]};

endmodule

// File: tb/tb_anabellek_hakem.sv
// Bench for anabellek_hakem: a round-robin instance (dut) and a fixed-priority
// instance (dut_fp) share all inputs. A single per-cycle step task acts as
// memory responder and scoreboard: expected iomem requests and expected
// completions are queued when stimulus is driven and popped when seen.
module tb_anabellek_hakem;

   localparam int N  = 3;
   localparam int AB = 17;
   localparam int ZA = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    ist_valid;
   logic [4*N-1:0]  ist_wstrb;
   logic [AB*N-1:0] ist_addr;
   logic [32*N-1:0] ist_wdata;
   logic            iomem_ready;
   logic [31:0]     iomem_rdata;
   logic            tmr_sec;
   logic [31:0]     tmr_adr;
   logic            hata_temizle;

   logic [N-1:0]    ready1;
   logic [31:0]     rdata1, addr1, wdata1, tmr_veri1;
   logic [3:0]      wstrb1;
   logic            iomem_valid1, hata1;

   logic [N-1:0]    ready2;
   logic [31:0]     addr2;
   logic [31:0]     rdata2_unused, wdata2_unused, tmr_veri2_unused;
   logic [3:0]      wstrb2_unused;
   logic            iomem_valid2_unused, hata2_unused;

   always #5 clk = ~clk;

   anabellek_hakem #(.KANAL_SAYISI(N), .ADR_BIT(AB), .TABAN_ADR(32'h4000_0000),
                     .ONCELIK_MODU(1), .ZAMAN_ASIMI(ZA)) dut (
      .clk_i(clk), .rst_i(rst),
      .ist_valid_i(ist_valid), .ist_ready_o(ready1), .ist_wstrb_i(ist_wstrb),
      .ist_addr_i(ist_addr), .ist_wdata_i(ist_wdata), .ist_rdata_o(rdata1),
      .iomem_valid(iomem_valid1), .iomem_ready(iomem_ready), .iomem_wstrb(wstrb1),
      .iomem_addr(addr1), .iomem_wdata(wdata1), .iomem_rdata(iomem_rdata),
      .tmr_sec_i(tmr_sec), .tmr_adr_i(tmr_adr), .tmr_veri_o(tmr_veri1),
      .hata_o(hata1), .hata_temizle_i(hata_temizle));

   anabellek_hakem #(.KANAL_SAYISI(N), .ADR_BIT(AB), .TABAN_ADR(32'h4000_0000),
                     .ONCELIK_MODU(0), .ZAMAN_ASIMI(ZA)) dut_fp (
      .clk_i(clk), .rst_i(rst),
      .ist_valid_i(ist_valid), .ist_ready_o(ready2), .ist_wstrb_i(ist_wstrb),
      .ist_addr_i(ist_addr), .ist_wdata_i(ist_wdata), .ist_rdata_o(rdata2_unused),
      .iomem_valid(iomem_valid2_unused), .iomem_ready(iomem_ready), .iomem_wstrb(wstrb2_unused),
      .iomem_addr(addr2), .iomem_wdata(wdata2_unused), .iomem_rdata(iomem_rdata),
      .tmr_sec_i(tmr_sec), .tmr_adr_i(tmr_adr), .tmr_veri_o(tmr_veri2_unused),
      .hata_o(hata2_unused), .hata_temizle_i(hata_temizle));

   typedef struct { logic [N-1:0] vec; logic [31:0] data; } cmp_t;
   typedef struct { logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } req_t;

   cmp_t         exp_q[$];
   req_t         req_q[$];
   logic [N-1:0] exp2_q[$];
   int           done_cyc[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_done = 0;
   int wcnt = 0;
   int vstart = 0;
   int mem_lat = 0;
   logic [31:0] mem_xor = '0;
   logic chk2_en = 1'b0;
   logic [31:0] h_addr, h_wdata;
   logic [3:0]  h_wstrb;

   logic [AB-1:0] ch_addr  [N];
   logic [3:0]    ch_wstrb [N];
   logic [31:0]   ch_wdata [N];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ea(input logic [AB-1:0] a);
      return (32'h4000_0000 & 32'hFFF8_0000) | {13'd0, a, 2'b00};
   endfunction

   task automatic set_ch(input int k, input logic [AB-1:0] a, input logic [3:0] s, input logic [31:0] d);
      ch_addr[k] = a; ch_wstrb[k] = s; ch_wdata[k] = d;
      ist_addr[k*AB +: AB] = a;
      ist_wstrb[4*k +: 4]  = s;
      ist_wdata[32*k +: 32] = d;
   endtask

   // Queue one transaction on channel k; timeout transactions carry DEAD_BEEF.
   task automatic expect_tx(input int k, input bit to);
      req_t r;
      cmp_t e;
      r.addr = ea(ch_addr[k]); r.wstrb = ch_wstrb[k]; r.wdata = ch_wdata[k];
      req_q.push_back(r);
      e.vec = N'(1) << k;
      e.data = to ? 32'hDEAD_BEEF : (ea(ch_addr[k]) ^ mem_xor);
      exp_q.push_back(e);
   endtask

   task automatic step();
      cmp_t e;
      req_t r;
      logic [N-1:0] v2;
      @(negedge clk);
      cyc++;
      if (ready1 != '0) begin
         if (exp_q.size() == 0) check_eq("unexpected_ready", 64'(ready1), 64'd0);
         else begin
            e = exp_q.pop_front();
            check_eq("ready_vec", 64'(ready1), 64'(e.vec));
            check_eq("rdata", 64'(rdata1), 64'(e.data));
         end
         n_done++;
         done_cyc.push_back(cyc);
      end
      if (chk2_en && ready2 != '0) begin
         if (exp2_q.size() == 0) check_eq("fp_unexpected_ready", 64'(ready2), 64'd0);
         else begin
            v2 = exp2_q.pop_front();
            check_eq("fp_ready_vec", 64'(ready2), 64'(v2));
         end
      end
      if (iomem_valid1) begin
         if (wcnt == 0) begin
            vstart = cyc;
            if (req_q.size() == 0) check_eq("unexpected_req", 64'd1, 64'd0);
            else begin
               r = req_q.pop_front();
               check_eq("req_addr", 64'(addr1), 64'(r.addr));
               check_eq("req_wstrb", 64'(wstrb1), 64'(r.wstrb));
               check_eq("req_wdata", 64'(wdata1), 64'(r.wdata));
            end
            h_addr = addr1; h_wstrb = wstrb1; h_wdata = wdata1;
         end else begin
            check_eq("hold_addr", 64'(addr1), 64'(h_addr));
            check_eq("hold_wstrb", 64'(wstrb1), 64'(h_wstrb));
            check_eq("hold_wdata", 64'(wdata1), 64'(h_wdata));
         end
         iomem_ready = (wcnt == mem_lat);
         iomem_rdata = iomem_ready ? (addr1 ^ mem_xor) : $urandom();
         wcnt++;
      end else begin
         wcnt = 0;
         iomem_ready = 1'b0;
         iomem_rdata = $urandom();
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int t = 0;
      while (n_done < target && t < budget) begin
         step();
         t++;
      end
      check_eq("done_count", 64'(n_done), 64'(target));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ist_valid = '0;
      step();
      rst = 1'b0;
      exp_q.delete(); req_q.delete(); exp2_q.delete();
   endtask

   initial begin
      int base, i0, a;
      logic [N-1:0] seen;
      rst = 1'b1; ist_valid = '0; ist_wstrb = '0; ist_addr = '0; ist_wdata = '0;
      iomem_ready = 1'b0; iomem_rdata = '0; tmr_sec = 1'b0; tmr_adr = '0; hata_temizle = 1'b0;
      for (int k = 0; k < N; k++) set_ch(k, '0, '0, '0);
      repeat (3) step();

      // Reset state
      check_eq("rst_valid", 64'(iomem_valid1), 64'd0);
      check_eq("rst_addr", 64'(addr1), 64'd0);
      check_eq("rst_wstrb", 64'(wstrb1), 64'd0);
      check_eq("rst_wdata", 64'(wdata1), 64'd0);
      check_eq("rst_ready", 64'(ready1), 64'd0);
      check_eq("rst_rdata", 64'(rdata1), 64'd0);
      check_eq("rst_hata", 64'(hata1), 64'd0);
      check_eq("tmr_unselected", 64'(tmr_veri1), 64'd0);
      tmr_sec = 1'b1; #1;
      check_eq("rst_sayac", 64'(tmr_veri1), 64'd0);
      tmr_sec = 1'b0;
      rst = 1'b0;

      // Counter advances one per cycle; only bit 2 of the address decodes
      step();
      tmr_sec = 1'b1; tmr_adr = 32'hFFFF_FFFB; #1;
      a = int'(tmr_veri1);
      repeat (5) step();
      #1 check_eq("sayac_step", 64'(tmr_veri1 - 32'(a)), 64'd5);
      tmr_sec = 1'b0; tmr_adr = '0;

      // Single read on ch1, memory acks two cycles after valid
      set_ch(0, 17'h00100, 4'h0, 32'h0000_AAAA);
      set_ch(1, 17'h00010, 4'h0, 32'h1111_1111);
      set_ch(2, 17'h1FFFF, 4'h0, 32'h2222_2222);
      mem_lat = 2; mem_xor = 32'h1234_5678 ^ 32'h4000_0040;
      check_eq("single_addr_model", 64'(ea(17'h00010)), 64'h4000_0040);
      expect_tx(1, 1'b0);
      ist_valid = 3'b010; base = n_done;
      wait_done(base + 1, 20);
      ist_valid = '0;
      check_eq("single_latency", 64'(done_cyc[done_cyc.size()-1] - vstart), 64'd3);
      step();
      check_eq("pulse_width", 64'(ready1), 64'd0);

      // Round-robin with all three channels held and immediate ack
      do_reset();
      mem_lat = 0; mem_xor = 32'h5A5A_0F0F;
      for (int r = 0; r < 6; r++) expect_tx(r % 3, 1'b0);
      i0 = done_cyc.size();
      ist_valid = 3'b111; base = n_done;
      wait_done(base + 6, 60);
      ist_valid = '0;
      for (int i = 1; i < 6; i++)
         check_eq("rr_spacing", 64'(done_cyc[i0+i] - done_cyc[i0+i-1]), 64'd3);

      // Fixed priority (dut_fp) vs round-robin (dut) with ch0 and ch2 held
      do_reset();
      chk2_en = 1'b1;
      expect_tx(0, 1'b0); expect_tx(2, 1'b0); expect_tx(0, 1'b0); expect_tx(2, 1'b0);
      expect_tx(2, 1'b0);
      for (int i = 0; i < 4; i++) exp2_q.push_back(3'b001);
      exp2_q.push_back(3'b100);
      ist_valid = 3'b101; base = n_done;
      wait_done(base + 4, 40);
      ist_valid = 3'b100;
      wait_done(base + 5, 20);
      ist_valid = '0;
      repeat (3) step();
      check_eq("fp_all_seen", 64'(exp2_q.size()), 64'd0);
      chk2_en = 1'b0;

      // Write on ch2, strobes and data held through ISTEK
      set_ch(2, 17'h1ABCD, 4'b0011, 32'hCAFE_F00D);
      mem_lat = 3;
      check_eq("write_addr_model", 64'(ea(17'h1ABCD)), 64'h4006_AF34);
      expect_tx(2, 1'b0);
      ist_valid = 3'b100; base = n_done;
      wait_done(base + 1, 20);
      ist_valid = '0;
      repeat (4) step();
      check_eq("write_one_pulse", 64'(n_done), 64'(base + 1));

      // Timeout with a clear arriving on the same edge: flag still set
      set_ch(0, 17'h00004, 4'h0, 32'h0BAD_0BAD);
      mem_lat = -1;
      expect_tx(0, 1'b1);
      ist_valid = 3'b001; base = n_done;
      for (int t = 0; t < 40 && n_done < base + 1; t++) begin
         step();
         hata_temizle = (iomem_valid1 && (cyc - vstart == ZA));
      end
      hata_temizle = 1'b0;
      check_eq("timeout_done", 64'(n_done), 64'(base + 1));
      check_eq("timeout_latency", 64'(done_cyc[done_cyc.size()-1] - vstart), 64'(ZA + 1));
      check_eq("hata_set", 64'(hata1), 64'd1);
      ist_valid = '0;
      repeat (3) step();
      check_eq("hata_sticky", 64'(hata1), 64'd1);
      hata_temizle = 1'b1;
      step();
      hata_temizle = 1'b0;
      check_eq("hata_cleared", 64'(hata1), 64'd0);

      // Normal service after the timeout
      mem_lat = 0;
      expect_tx(1, 1'b0);
      ist_valid = 3'b010; base = n_done;
      wait_done(base + 1, 20);
      ist_valid = '0;
      check_eq("after_timeout_hata", 64'(hata1), 64'd0);

      // Ready arriving on the timeout cycle wins
      mem_lat = ZA;
      expect_tx(1, 1'b0);
      ist_valid = 3'b010; base = n_done;
      wait_done(base + 1, 30);
      ist_valid = '0;
      check_eq("tie_latency", 64'(done_cyc[done_cyc.size()-1] - vstart), 64'(ZA + 1));
      check_eq("tie_no_hata", 64'(hata1), 64'd0);
      mem_lat = 0;

      // Tear-free timer read across a carry out of the low word
      step();
      force dut.sayac_q = 64'h0000_0000_FFFF_FFFF;
      tmr_sec = 1'b1; tmr_adr = 32'h0; #1;
      check_eq("tmr_lo", 64'(tmr_veri1), 64'h0000_0000_FFFF_FFFF);
      release dut.sayac_q;
      step();
      tmr_sec = 1'b0;
      repeat (4) step();
      tmr_sec = 1'b1; tmr_adr = 32'h4; #1;
      check_eq("tmr_hi_snapshot", 64'(tmr_veri1), 64'd0);
      tmr_adr = 32'h0;
      step();
      tmr_adr = 32'h4; #1;
      check_eq("tmr_hi_after_carry", 64'(tmr_veri1), 64'd1);
      tmr_sec = 1'b0; #1;
      check_eq("tmr_deselected", 64'(tmr_veri1), 64'd0);

      // Reset during ISTEK: everything drops, no pulse
      set_ch(0, 17'h0F0F0, 4'b1111, 32'h7777_8888);
      mem_lat = -1;
      begin
         req_t r;
         r.addr = ea(ch_addr[0]); r.wstrb = ch_wstrb[0]; r.wdata = ch_wdata[0];
         req_q.push_back(r);
      end
      ist_valid = 3'b001;
      repeat (3) step();
      check_eq("mid_valid_before", 64'(iomem_valid1), 64'd1);
      rst = 1'b1; ist_valid = '0;
      step();
      check_eq("mid_valid", 64'(iomem_valid1), 64'd0);
      check_eq("mid_addr", 64'(addr1), 64'd0);
      check_eq("mid_wstrb", 64'(wstrb1), 64'd0);
      check_eq("mid_wdata", 64'(wdata1), 64'd0);
      check_eq("mid_ready", 64'(ready1), 64'd0);
      check_eq("mid_rdata", 64'(rdata1), 64'd0);
      rst = 1'b0;
      req_q.delete();
      seen = '0;
      for (int t = 0; t < 6; t++) begin
         step();
         seen = seen | ready1;
      end
      check_eq("mid_no_pulse", 64'(seen), 64'd0);

      check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
      check_eq("req_q_empty", 64'(req_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
